// File: rtl/ro_puf_response_gen_if.sv
// Run-control bundle between a host and the RO-PUF measurement controller:
// run request and base challenge in, busy/done status and response out.
interface ro_puf_response_gen_if #(
  parameter int CHAL_W = 5,
  parameter int NBITS  = 8
);
  logic              start;
  logic [CHAL_W-1:0] chal_seed;
  logic              busy;
  logic              done;
  logic [NBITS-1:0]  response;

  modport master (
    output start, chal_seed,
    input  busy, done, response
  );

  modport slave (
    input  start, chal_seed,
    output busy, done, response
  );
endinterface

// File: rtl/ro_puf_response_gen.sv
// RO-PUF response generator: per challenge, settle, count synchronised
// RO edges over a window, compare bank A vs bank B, assemble NBITS bits.
module ro_puf_response_gen #(
  parameter int CHAL_W = 5,
  parameter int NBITS  = 8,
  parameter int CNT_W  = 16,
  parameter int SETTLE = 16,
  parameter int WINDOW = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ro_a,
  input  logic              ro_b,
  output logic              ro_en,
  output logic [CHAL_W-1:0] sel,
  ro_puf_response_gen_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_MEAS   = 3'd2;
  localparam logic [2:0] S_CMP    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int TMAX = (SETTLE > WINDOW) ? SETTLE : WINDOW;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int IW   = (NBITS > 1) ? $clog2(NBITS) : 1;

  localparam logic [TW-1:0] SET_LAST = TW'(SETTLE - 1);
  localparam logic [TW-1:0] WIN_LAST = TW'(WINDOW - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NBITS - 1);

  logic [2:0]        state_q, state_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CHAL_W-1:0] seed_q, seed_d;
  logic [CHAL_W-1:0] sel_q, sel_d;
  logic              ro_en_q, ro_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [NBITS-1:0]  resp_q, resp_d;
  logic [NBITS-1:0]  shadow_q, shadow_d;
  logic [CNT_W-1:0]  cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0]  cnt_b_q, cnt_b_d;
  logic [2:0]        sync_a_q, sync_a_d;
  logic [2:0]        sync_b_q, sync_b_d;
  logic              edge_a, edge_b;

  // [0],[1] form the synchroniser; [2] is the delayed copy for edge detect
  assign sync_a_d = {sync_a_q[1:0], ro_a};
  assign sync_b_d = {sync_b_q[1:0], ro_b};
  assign edge_a   = sync_a_q[1] & ~sync_a_q[2];
  assign edge_b   = sync_b_q[1] & ~sync_b_q[2];

  assign ro_en        = ro_en_q;
  assign sel          = sel_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.response = resp_q;

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    idx_d    = idx_q;
    seed_d   = seed_q;
    sel_d    = sel_q;
    ro_en_d  = ro_en_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    resp_d   = resp_q;
    shadow_d = shadow_q;
    cnt_a_d  = cnt_a_q;
    cnt_b_d  = cnt_b_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_SETTLE;
          busy_d   = 1'b1;
          ro_en_d  = 1'b1;
          idx_d    = '0;
          tmr_d    = '0;
          shadow_d = '0;
          seed_d   = bus.chal_seed;
          sel_d    = bus.chal_seed;
        end
      end
      S_SETTLE: begin
        cnt_a_d = '0;
        cnt_b_d = '0;
        if (tmr_q == SET_LAST) begin
          tmr_d   = '0;
          state_d = S_MEAS;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_MEAS: begin
        if (edge_a && (cnt_a_q != '1)) cnt_a_d = cnt_a_q + CNT_W'(1);
        if (edge_b && (cnt_b_q != '1)) cnt_b_d = cnt_b_q + CNT_W'(1);
        if (tmr_q == WIN_LAST) begin
          tmr_d   = '0;
          state_d = S_CMP;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_CMP: begin
        shadow_d[idx_q] = (cnt_a_q > cnt_b_q);
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          // next challenge lands at the start of SETTLE so mux glitches are discarded
          idx_d   = idx_q + IW'(1);
          sel_d   = seed_q + CHAL_W'(idx_q) + CHAL_W'(1);
          state_d = S_SETTLE;
        end
      end
      S_DONE: begin
        resp_d  = shadow_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        ro_en_d = 1'b0;
        sel_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      tmr_q    <= '0;
      idx_q    <= '0;
      seed_q   <= '0;
      sel_q    <= '0;
      ro_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      resp_q   <= '0;
      shadow_q <= '0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      sync_a_q <= '0;
      sync_b_q <= '0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      idx_q    <= idx_d;
      seed_q   <= seed_d;
      sel_q    <= sel_d;
      ro_en_q  <= ro_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      resp_q   <= resp_d;
      shadow_q <= shadow_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
      sync_a_q <= sync_a_d;
      sync_b_q <= sync_b_d;
    end
  end

endmodule

// File: tb/tb_ro_puf_response_gen.sv
// Directed bench for ro_puf_response_gen: synthetic RO waveforms, scoreboard
// of expected responses and challenge sequences, latency and reset checks.
module tb_ro_puf_response_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #10 clk = ~clk;

  logic       ro_a, ro_b, ro_en;
  logic [4:0] sel;
  logic       ro_en2;
  logic [4:0] sel2;

  ro_puf_response_gen_if #(.CHAL_W(5), .NBITS(8)) bus ();
  ro_puf_response_gen_if #(.CHAL_W(5), .NBITS(8)) bus2 ();

  ro_puf_response_gen #(
    .CHAL_W(5), .NBITS(8), .CNT_W(16), .SETTLE(4), .WINDOW(64)
  ) dut (
    .clk(clk), .reset(reset), .ro_a(ro_a), .ro_b(ro_b),
    .ro_en(ro_en), .sel(sel), .bus(bus)
  );

  logic wa3 = 1'b0;
  logic wb2 = 1'b0;

  ro_puf_response_gen #(
    .CHAL_W(5), .NBITS(8), .CNT_W(4), .SETTLE(4), .WINDOW(64)
  ) dut_sat (
    .clk(clk), .reset(reset), .ro_a(wa3), .ro_b(wb2),
    .ro_en(ro_en2), .sel(sel2), .bus(bus2)
  );

  // waveform generators
  int   pa = 4;
  int   pb = 8;
  bit   amode = 1'b0;
  bit   parity = 1'b0;
  int   cyc = 0;
  logic sa = 1'b0;
  logic sb = 1'b0;
  logic aa = 1'b0;
  logic ab = 1'b0;

  always @(negedge clk) begin
    int ea, eb;
    cyc++;
    ea = (parity && sel[0]) ? pb : pa;
    eb = (parity && sel[0]) ? pa : pb;
    sa = (cyc % ea) < (ea / 2);
    sb = (cyc % eb) < (eb / 2);
    wa3 = (cyc % 3) < 1;
    wb2 = (cyc % 2) < 1;
  end

  always #37 aa = ~aa;
  always #73 ab = ~ab;

  assign ro_a = amode ? aa : sa;
  assign ro_b = amode ? ab : sb;

  // monitor: records challenge sequence and responses
  logic [4:0] obs_sel[$];
  logic [7:0] obs_resp[$];
  int         done_cnt = 0;
  logic       busy_p = 1'b0;
  logic [4:0] sel_p = '0;

  always @(posedge clk) begin
    #1;
    if (bus.busy && (!busy_p || sel != sel_p)) obs_sel.push_back(sel);
    if (bus.done) begin
      obs_resp.push_back(bus.response);
      done_cnt++;
    end
    busy_p = bus.busy;
    sel_p  = sel;
  end

  logic [4:0] exp_sel[$];
  logic [7:0] exp_resp[$];
  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [4:0] seed, input logic [7:0] exp,
                     input bit poke);
    int lat;
    logic [4:0] es, os;
    logic [7:0] er, orr;
    for (int k = 0; k < 8; k++) exp_sel.push_back(seed + 5'(k));
    exp_resp.push_back(exp);
    @(negedge clk);
    bus.start = 1'b1;
    bus.chal_seed = seed;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 300) begin
        chk("ro_en_mid_run", 32'(ro_en), 1);
        chk("busy_mid_run", 32'(bus.busy), 1);
      end
      if (poke && lat == 100) begin
        bus.start = 1'b1;
        bus.chal_seed = 5'h0A;
      end
      if (poke && lat == 101) bus.start = 1'b0;
    end while (!bus.done && lat < 3000);
    chk("done_timeout", 32'(lat < 3000), 1);
    chk("latency", 32'(lat), 553);
    @(negedge clk);
    chk("busy_after_done", 32'(bus.busy), 0);
    chk("ro_en_after_done", 32'(ro_en), 0);
    chk("sel_after_done", 32'(sel), 0);
    chk("sel_count", 32'(obs_sel.size()), 8);
    while (exp_sel.size() > 0) begin
      es = exp_sel.pop_front();
      os = (obs_sel.size() > 0) ? obs_sel.pop_front() : 5'bx;
      chk("sel_seq", 32'(os), 32'(es));
    end
    while (exp_resp.size() > 0) begin
      er = exp_resp.pop_front();
      orr = (obs_resp.size() > 0) ? obs_resp.pop_front() : 8'bx;
      chk("response", 32'(orr), 32'(er));
    end
    obs_sel.delete();
    obs_resp.delete();
  endtask

  initial begin
    int d0, lat2;
    bus.start = 1'b0;
    bus.chal_seed = '0;
    bus2.start = 1'b0;
    bus2.chal_seed = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_ro_en", 32'(ro_en), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_response", 32'(bus.response), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // A faster than B
    pa = 4; pb = 8;
    run(5'h00, 8'hFF, 1'b0);
    // B faster than A, then a tie
    pa = 8; pb = 4;
    run(5'h03, 8'h00, 1'b0);
    pa = 4; pb = 4;
    run(5'h09, 8'h00, 1'b0);
    // faster RO chosen by challenge parity, sel wraps past 1F
    pa = 4; pb = 8; parity = 1'b1;
    run(5'h1E, 8'h55, 1'b0);
    parity = 1'b0;

    // 4-bit counters: ~21 vs 32 edges both pin at 15 -> tie
    @(negedge clk);
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    lat2 = 0;
    while (!bus2.done && lat2 < 3000) begin
      @(posedge clk);
      #1;
      lat2++;
    end
    chk("sat_timeout", 32'(lat2 < 3000), 1);
    chk("sat_response", 32'(bus2.response), 0);

    // reset during MEASURE of bit 3
    pa = 4; pb = 8;
    d0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.chal_seed = 5'h00;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (240) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_ro_en", 32'(ro_en), 0);
    chk("abort_response", 32'(bus.response), 0);
    chk("abort_sel", 32'(sel), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 0);
    obs_sel.delete();
    obs_resp.delete();
    run(5'h00, 8'hFF, 1'b0);

    // asynchronous ROs, start poked while busy
    amode = 1'b1;
    d0 = done_cnt;
    run(5'h00, 8'hFF, 1'b1);
    repeat (100) @(negedge clk);
    chk("single_done", 32'(done_cnt - d0), 1);
    chk("no_x", 32'($isunknown({bus.response, bus.busy, bus.done, ro_en, sel})), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
